// File: rtl/modn_run_ctrl.sv
// Run controller for the modulo-N counter: sequences 0..term for nper periods,
// flags each wrap, and handles aborts and illegal-config rejection.
module modn_run_ctrl #(
  parameter int W  = 3,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  mod_in,
  input  logic [PW-1:0] periods_in,
  input  logic          stop,
  output logic          ready,
  output logic          busy,
  output logic [W-1:0]  cnt,
  output logic          wrap,
  output logic          done,
  output logic          aborted,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_cnt;
  logic [W-1:0]  r_term;
  logic [PW-1:0] r_pc;
  logic [PW-1:0] r_nper;
  logic          r_abt;
  logic          r_err;

  logic w_wrap;
  logic w_last;

  assign w_wrap = (r_state == S_RUN) && (r_cnt == r_term);
  // nper==0 means free-run: pc wraps silently, only stop ends it
  assign w_last = (r_nper != '0) && (r_pc == r_nper - PW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_term  <= '0;
      r_pc    <= '0;
      r_nper  <= '0;
      r_abt   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_abt <= 1'b0;
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (start) begin
            if (mod_in != '0) begin
              r_term  <= mod_in;
              r_nper  <= periods_in;
              r_pc    <= '0;
              r_state <= S_RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_cnt <= w_wrap ? '0 : r_cnt + W'(1);
          if (w_wrap) r_pc <= r_pc + PW'(1);
          // stop wins over a coincident final wrap
          if (stop) begin
            r_state <= S_DONE;
            r_abt   <= 1'b1;
            r_cnt   <= '0;
          end else if (w_wrap && w_last) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
          end
        end
        S_DONE: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready   = (r_state == S_IDLE);
  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign cnt     = r_cnt;
  assign wrap    = w_wrap;
  assign aborted = r_abt;
  assign err     = r_err;

endmodule

// File: tb/tb_modn_run_ctrl.sv
// Directed bench for modn_run_ctrl: inputs change and outputs are
// sampled on the falling edge, the DUT acts on the rising edge.
module tb_modn_run_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] mod_in;
  logic [3:0] periods_in;
  logic       stop;
  logic       ready;
  logic       busy;
  logic [2:0] cnt;
  logic       wrap;
  logic       done;
  logic       aborted;
  logic       err;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  modn_run_ctrl #(.W(3), .PW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mod_in     (mod_in),
    .periods_in (periods_in),
    .stop       (stop),
    .ready      (ready),
    .busy       (busy),
    .cnt        (cnt),
    .wrap       (wrap),
    .done       (done),
    .aborted    (aborted),
    .err        (err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ready"}, int'(ready), 1);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".done"}, int'(done), 0);
    chk({tag, ".cnt"}, int'(cnt), 0);
  endtask

  // Full normal run; optionally pokes start/mod_in/periods_in mid-run.
  task automatic do_run(input int m, input int p, input bit poke);
    int n;
    n = (m + 1) * p;
    start      = 1'b1;
    mod_in     = 3'(m);
    periods_in = 4'(p);
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("run.busy", int'(busy), 1);
      chk("run.cnt", int'(cnt), i % (m + 1));
      chk("run.wrap", int'(wrap), int'((i % (m + 1)) == m));
      chk("run.done", int'(done), 0);
      if (poke && i == 2) begin
        start      = 1'b1;
        mod_in     = 3'd1;
        periods_in = 4'd7;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("fin.done", int'(done), 1);
    chk("fin.aborted", int'(aborted), 0);
    chk("fin.busy", int'(busy), 0);
    chk("fin.ready", int'(ready), 0);
    chk("fin.cnt", int'(cnt), 0);
    tick();
    chk_idle("post");
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    mod_in     = '0;
    periods_in = '0;
    tick();
    tick();
    chk_idle("rst");
    chk("rst.wrap", int'(wrap), 0);
    chk("rst.err", int'(err), 0);
    chk("rst.aborted", int'(aborted), 0);
    rst = 1'b0;

    do_run(4, 2, 1'b0);
    do_run(1, 3, 1'b0);
    do_run(3, 2, 1'b1);

    // illegal config, then legal start in the err cycle
    start  = 1'b1;
    mod_in = 3'd0;
    periods_in = 4'd1;
    tick();
    chk("ill.err", int'(err), 1);
    chk("ill.busy", int'(busy), 0);
    chk("ill.ready", int'(ready), 1);
    mod_in = 3'd2;
    tick();
    start = 1'b0;
    chk("ill.err2", int'(err), 0);
    chk("ill.busy2", int'(busy), 1);
    chk("ill.cnt0", int'(cnt), 0);
    tick();
    chk("ill.cnt1", int'(cnt), 1);
    tick();
    chk("ill.cnt2", int'(cnt), 2);
    chk("ill.wrap", int'(wrap), 1);
    tick();
    chk("ill.done", int'(done), 1);
    tick();
    chk_idle("ill.post");

    // free-run mod 8, stop at cnt=5
    start      = 1'b1;
    mod_in     = 3'd7;
    periods_in = 4'd0;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("fr.cnt5", int'(cnt), 5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("fr.done", int'(done), 1);
    chk("fr.aborted", int'(aborted), 1);
    chk("fr.cnt", int'(cnt), 0);
    chk("fr.busy", int'(busy), 0);
    tick();
    chk_idle("fr.post");
    chk("fr.abt_clr", int'(aborted), 0);

    // free-run past the period-counter wrap: no self-termination
    start      = 1'b1;
    mod_in     = 3'd1;
    periods_in = 4'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("fr2.busy", int'(busy), 1);
      chk("fr2.cnt", int'(cnt), i % 2);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("fr2.done", int'(done), 1);
    chk("fr2.aborted", int'(aborted), 1);
    tick();

    // stop coincident with final wrap
    start      = 1'b1;
    mod_in     = 3'd2;
    periods_in = 4'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("col.wrap", int'(wrap), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("col.done", int'(done), 1);
    chk("col.aborted", int'(aborted), 1);
    tick();

    // stop in idle is ignored
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("istop");
    end
    stop = 1'b0;

    // reset mid-run at cnt=3
    start      = 1'b1;
    mod_in     = 3'd4;
    periods_in = 4'd3;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("mr.cnt3", int'(cnt), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("mr");
    chk("mr.wrap", int'(wrap), 0);
    chk("mr.aborted", int'(aborted), 0);
    tick();
    chk_idle("mr.post");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/modn_run_ctrl.md
# modn_run_ctrl

Run controller for the modulo-N counter datapath. Accepts a run request carrying a terminal value and a period count, sequences the counter from 0 to the terminal value for the requested number of full periods, and flags every wrap. It also handles aborts and rejects illegal configurations. It sits between a host/test sequencer and any logic that consumes `cnt`/`wrap`, such as slot timers and clock dividers. The existing fixed mod-5 behaviour is the case `mod_in=4`.

## Interface
- `W`, default 3: count width; terminal values 1..2^W-1.
- `PW`, default 4: period-count width.

- `clk`  in  1  : single clock, rising-edge.
- `rst`  in  1  : synchronous, active-high reset. Sampled on `clk` rising edge.
- `start`  in  1  : run request. Sampled only when `ready`=1.
- `mod_in`  in  W  : terminal count; modulus = `mod_in`+1. Value 0 is illegal.
- `periods_in`  in  PW  : number of full periods to run; 0 = free-run until `stop`.
- `stop`  in  1  : abort request. Honoured only in RUN.
- `ready`  out  1  : controller idle, can accept `start`.
- `busy`  out  1  : run in progress (RUN state).
- `cnt`  out  W  : current count.
- `wrap`  out  1  : `cnt` is at the terminal value in RUN; next cycle `cnt`=0.
- `done`  out  1  : one-cycle pulse, run finished (normal or aborted).
- `aborted`  out  1  : qualifies `done`; 1 when the finish was caused by `stop`.
- `err`  out  1  : one-cycle pulse, `start` rejected (`mod_in`=0).

## Operation
- States: IDLE, RUN, DONE. Encoding is free; all outputs are registered or decoded from registered state only.
- IDLE:
  - `ready`=1, `cnt`=0.
  - `start`=1 with `mod_in`≠0: latch `term`=`mod_in` and `nper`=`periods_in`, clear period counter `pc`, go to RUN.
  - `start`=1 with `mod_in`=0: `err`=1 next cycle, stay IDLE, no latch.
  - `stop` is ignored.
- RUN:
  - `busy`=1.
  - `wrap` = (`cnt`==`term`).
  - Each cycle `cnt` increments, or goes to 0 when `wrap`=1.
  - On `wrap`, `pc` increments, wrapping modulo 2^PW.
  - If `nper`≠0 and `wrap` and `pc`==`nper`-1: go to DONE with `aborted`=0.
  - If `stop`=1: go to DONE with `aborted`=1, regardless of `wrap`. `stop` has priority over normal completion in the same cycle.
  - `start` is ignored; latched config is immutable during a run.
- DONE:
  - Lasts exactly one cycle: `done`=1, `cnt`=0, `busy`=0, `ready`=0.
  - `aborted` holds its value for this cycle.
  - Next state: IDLE.
- Free-run (`nper`=0): `pc` wraps silently and only `stop` ends the run.
- Config is latched at accept; `mod_in`/`periods_in` changes afterwards have no effect.

## Timing
- Reset: state IDLE, `cnt`=0, `pc`=0, `term`=0, `nper`=0. Outputs `ready`=1; `busy`, `wrap`, `done`, `aborted`, `err` all 0.
- Reset mid-run takes effect on the next edge; no `done` is produced.
- `rst` has priority over `start`/`stop`.
- `start` accepted at edge k: at cycle k+1 `busy`=1 and `cnt`=0.
- Normal run length: (`term`+1)×`nper` RUN cycles, then 1 DONE cycle, then IDLE. The next `start` is accepted no earlier than the first IDLE cycle.
- `wrap` and `cnt`==`term` are coincident (same cycle).
- `err` appears one cycle after the rejected `start`. `ready` stays 1 throughout a rejection.
- `stop` sampled at edge j in RUN: DONE at cycle j+1, IDLE at j+2.

## Test plan
- Reset then mod-5 run: `rst`=1 for 2 cycles; `start`, `mod_in`=4, `periods_in`=2 → `cnt` 0,1,2,3,4,0,1,2,3,4; `wrap` on both 4s; next cycle `done`=1, `aborted`=0; following cycle `ready`=1.
- Minimum modulus: `mod_in`=1, `periods_in`=3 → `cnt` 0,1,0,1,0,1; three `wrap` pulses; `done` at cycle 7 after accept.
- Illegal config: `start` with `mod_in`=0 → `err`=1 for one cycle, `busy` stays 0, `ready` stays 1. Then a legal `start` is accepted on the next cycle.
- Abort and collision:
  - Free-run `mod_in`=7, `periods_in`=0: `stop` asserted when `cnt`=5 → DONE next cycle with `aborted`=1, `cnt`=0.
  - Repeat with `stop` coincident with the final `wrap` of a 1-period run → `aborted`=1.
- Ignored inputs: `start` pulsed and `mod_in` changed mid-run → sequence unchanged. `stop` in IDLE → no `done`.
- Reset mid-run: `rst` asserted at `cnt`=3 → next cycle all reset values, no `done` pulse.
